// File: rtl/sarray_drain.sv
// sarray_drain: deskews the bottom edge of a systolic array into whole rows, queues them and tracks tile completion
//   clk, rst                 clock and asynchronous active-high reset
//   start_i, rows_i          arm a new tile of rows_i result rows (accepted only in IDLE)
//   col_valid/cnt/data_i     skewed bottom-edge results; column c lags column 0 by c cycles
//   stall_o                  upstream must stop issuing rows (free entries <= COLS)
//   row_valid/ready_i        de-skewed row handshake; row_cnt_o, row_data_o, row_last_o describe the head row
//   busy_o, done_o           tile in progress / one-cycle completion pulse
//   err_o                    sticky [0] FIFO overflow, [1] partial row or tag mismatch
module sarray_drain #(
   parameter int COLS   = 8,
   parameter int DATA_W = 32,
   parameter int CNT_W  = 8,
   parameter int DEPTH  = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start_i,
   input  logic [CNT_W-1:0]         rows_i,
   input  logic [COLS-1:0]          col_valid_i,
   input  logic [COLS*CNT_W-1:0]    col_cnt_i,
   input  logic [COLS*DATA_W-1:0]   col_data_i,
   output logic                     stall_o,
   output logic                     row_valid_o,
   input  logic                     row_ready_i,
   output logic [CNT_W-1:0]         row_cnt_o,
   output logic [COLS*DATA_W-1:0]   row_data_o,
   output logic                     row_last_o,
   output logic                     busy_o,
   output logic                     done_o,
   output logic [1:0]               err_o
);
   localparam int AW = $clog2(DEPTH);
   typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;
   state_t state, state_nx;
   logic [COLS-1:0] a_v;
   logic [CNT_W-1:0] a_t [COLS];
   logic [COLS*DATA_W-1:0] a_row;
   // column c is delayed by COLS-1-c so every column of a row lines up with the last column
   for (genvar c = 0; c < COLS; c++) begin : g_col
      localparam int D = COLS - 1 - c;
      if (D == 0) begin : g_pass
         assign a_v[c] = col_valid_i[c];
         assign a_t[c] = col_cnt_i[c*CNT_W +: CNT_W];
         assign a_row[c*DATA_W +: DATA_W] = col_data_i[c*DATA_W +: DATA_W];
      end else begin : g_dly
         logic [D-1:0] v_sr;
         logic [CNT_W-1:0] t_sr [D];
         logic [DATA_W-1:0] d_sr [D];
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               v_sr <= '0;
               for (int k = 0; k < D; k++) begin
                  t_sr[k] <= '0;
                  d_sr[k] <= '0;
               end
            end else begin
               v_sr[0] <= col_valid_i[c];
               t_sr[0] <= col_cnt_i[c*CNT_W +: CNT_W];
               d_sr[0] <= col_data_i[c*DATA_W +: DATA_W];
               for (int k = 1; k < D; k++) begin
                  v_sr[k] <= v_sr[k-1];
                  t_sr[k] <= t_sr[k-1];
                  d_sr[k] <= d_sr[k-1];
               end
            end
         end
         assign a_v[c] = v_sr[D-1];
         assign a_t[c] = t_sr[D-1];
         assign a_row[c*DATA_W +: DATA_W] = d_sr[D-1];
      end
   end
   logic tags_eq;
   always_comb begin
      tags_eq = 1'b1;
      for (int i = 1; i < COLS; i++) tags_eq = tags_eq & (a_t[i] == a_t[0]);
   end
   logic push, skew_err, empty, full, pop, wr, ovf, start_acc, is_last;
   logic [AW-1:0] wptr, rptr;
   logic [AW:0] cnt;
   logic [CNT_W-1:0] mem_t [DEPTH];
   logic [COLS*DATA_W-1:0] mem_d [DEPTH];
   logic [CNT_W-1:0] rows_q, pcnt;
   assign push     = (&a_v) && tags_eq;
   assign skew_err = (|a_v) && !push;
   assign empty    = cnt == '0;
   assign full     = cnt == (AW+1)'(DEPTH);
   assign pop      = !empty && row_ready_i;
   // a full FIFO still accepts a push when the head leaves in the same cycle
   assign wr       = push && (!full || pop);
   assign ovf      = push && full && !pop;
   assign stall_o  = cnt >= (AW+1)'(DEPTH - COLS);
   assign row_valid_o = !empty;
   assign row_cnt_o   = empty ? '0 : mem_t[rptr];
   assign row_data_o  = empty ? '0 : mem_d[rptr];
   always_ff @(posedge clk) begin
      if (wr) begin
         mem_t[wptr] <= a_t[0];
         mem_d[wptr] <= a_row;
      end
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr <= '0;
         rptr <= '0;
         cnt  <= '0;
      end else begin
         wptr <= wr ? wptr + 1'b1 : wptr;
         rptr <= pop ? rptr + 1'b1 : rptr;
         cnt  <= cnt + (AW+1)'(wr) - (AW+1)'(pop);
      end
   end
   assign start_acc  = (state == IDLE) && start_i;
   assign is_last    = pcnt == rows_q - CNT_W'(1);
   assign busy_o     = state == COLLECT;
   assign done_o     = state == DONE;
   assign row_last_o = (state == COLLECT) && is_last && row_valid_o;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         rows_q <= '0;
         pcnt   <= '0;
         err_o  <= '0;
      end else begin
         state  <= state_nx;
         rows_q <= start_acc ? rows_i : rows_q;
         pcnt   <= start_acc ? '0 : (state == COLLECT && pop) ? pcnt + 1'b1 : pcnt;
         err_o  <= (start_acc ? 2'b00 : err_o) | {skew_err, ovf};
      end
   end
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = start_i ? ((rows_i == '0) ? DONE : COLLECT) : IDLE;
         COLLECT: state_nx = (pop && is_last) ? DONE : COLLECT;
         default: state_nx = IDLE;
      endcase
   end
endmodule

// File: tb/tb_sarray_drain.sv
// tb_sarray_drain: directed scenarios for sarray_drain with hand-computed expectations
module tb_sarray_drain;
   localparam int COLS = 8, DATA_W = 32, CNT_W = 8, DEPTH = 16, RW = COLS*DATA_W;
   logic clk = 1'b0, rst = 1'b1, start_i = 1'b0, row_ready_i = 1'b0;
   logic [CNT_W-1:0] rows_i = '0;
   logic [COLS-1:0] col_valid_i = '0;
   logic [COLS*CNT_W-1:0] col_cnt_i = '0;
   logic [RW-1:0] col_data_i = '0;
   logic stall_o, row_valid_o, row_last_o, busy_o, done_o;
   logic [CNT_W-1:0] row_cnt_o;
   logic [RW-1:0] row_data_o;
   logic [1:0] err_o;
   int tests = 0, fails = 0, cyc = 0, done_cnt = 0, done_cyc = 0;
   int q_tag[$], q_cyc[$];
   logic [RW-1:0] q_data[$];
   logic q_last[$];

   sarray_drain #(.COLS(COLS), .DATA_W(DATA_W), .CNT_W(CNT_W), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .start_i(start_i), .rows_i(rows_i),
      .col_valid_i(col_valid_i), .col_cnt_i(col_cnt_i), .col_data_i(col_data_i),
      .stall_o(stall_o), .row_valid_o(row_valid_o), .row_ready_i(row_ready_i),
      .row_cnt_o(row_cnt_o), .row_data_o(row_data_o), .row_last_o(row_last_o),
      .busy_o(busy_o), .done_o(done_o), .err_o(err_o));

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;
   always @(negedge clk) begin
      if (!rst) begin
         if (row_valid_o && row_ready_i) begin
            q_tag.push_back(int'(row_cnt_o));
            q_data.push_back(row_data_o);
            q_last.push_back(row_last_o);
            q_cyc.push_back(cyc);
         end
         if (done_o) begin
            done_cnt++;
            done_cyc = cyc;
         end
      end
   end

   function automatic logic [RW-1:0] exp_row(input int tag);
      logic [RW-1:0] r;
      for (int c = 0; c < COLS; c++) r[c*DATA_W +: DATA_W] = DATA_W'(tag*16 + c);
      return r;
   endfunction

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clr_log();
      q_tag.delete(); q_data.delete(); q_last.delete(); q_cyc.delete();
      done_cnt = 0;
   endtask

   task automatic do_reset();
      rst = 1'b1; start_i = 1'b0; row_ready_i = 1'b0;
      col_valid_i = '0; col_cnt_i = '0; col_data_i = '0;
      tick(2);
      rst = 1'b0;
      clr_log();
   endtask

   task automatic pulse_start(input int n);
      start_i = 1'b1; rows_i = CNT_W'(n);
      tick(1);
      start_i = 1'b0;
   endtask

   // row r (tag tag0+r) column c is driven at step r+c; one column of one tag can be made a cycle late
   task automatic drive_rows(input int n, input int tag0, input int late_col, input int late_tag, input int pop_at);
      for (int k = 0; k < n + COLS; k++) begin
         col_valid_i = '0; col_cnt_i = '0; col_data_i = '0;
         if (pop_at >= 0) row_ready_i = (k == pop_at);
         for (int c = 0; c < COLS; c++) begin
            for (int r = 0; r < n; r++) begin
               int t;
               t = tag0 + r;
               if (k == r + c + ((c == late_col && t == late_tag) ? 1 : 0)) begin
                  col_valid_i[c] = 1'b1;
                  col_cnt_i[c*CNT_W +: CNT_W] = CNT_W'(t);
                  col_data_i[c*DATA_W +: DATA_W] = DATA_W'(t*16 + c);
               end
            end
         end
         tick(1);
      end
      col_valid_i = '0; col_cnt_i = '0; col_data_i = '0;
      if (pop_at >= 0) row_ready_i = 1'b0;
   endtask

   task automatic test_reset();
      tick(2);
      tests++; if ({row_valid_o, row_last_o, busy_o, done_o, stall_o, err_o} !== 7'b0) begin fails++; $display("FAIL reset_flags: got %b exp 0", {row_valid_o, row_last_o, busy_o, done_o, stall_o, err_o}); end
      tests++; if (row_cnt_o !== '0) begin fails++; $display("FAIL reset_cnt: got %0h exp 0", row_cnt_o); end
      tests++; if (row_data_o !== '0) begin fails++; $display("FAIL reset_data: got %0h exp 0", row_data_o); end
      rst = 1'b0;
      clr_log();
   endtask

   task automatic test_basic();
      do_reset();
      pulse_start(3);
      tests++; if (busy_o !== 1'b1) begin fails++; $display("FAIL basic_busy: got %b exp 1", busy_o); end
      row_ready_i = 1'b1;
      drive_rows(3, 0, -1, -1, -1);
      tick(3);
      row_ready_i = 1'b0;
      tests++; if (q_tag.size() !== 3) begin fails++; $display("FAIL basic_count: got %0d exp 3", q_tag.size()); end
      for (int i = 0; i < q_tag.size(); i++) begin
         tests++; if (q_tag[i] !== i) begin fails++; $display("FAIL basic_tag%0d: got %0d exp %0d", i, q_tag[i], i); end
         tests++; if (q_data[i] !== exp_row(i)) begin fails++; $display("FAIL basic_data%0d: got %0h exp %0h", i, q_data[i], exp_row(i)); end
         tests++; if (q_last[i] !== (i == 2)) begin fails++; $display("FAIL basic_last%0d: got %b exp %b", i, q_last[i], i == 2); end
      end
      tests++; if (done_cnt !== 1) begin fails++; $display("FAIL basic_done_count: got %0d exp 1", done_cnt); end
      if (q_cyc.size() == 3) begin
         tests++; if (done_cyc !== q_cyc[2] + 1) begin fails++; $display("FAIL basic_done_time: got %0d exp %0d", done_cyc, q_cyc[2] + 1); end
      end
      tests++; if (busy_o !== 1'b0) begin fails++; $display("FAIL basic_busy_end: got %b exp 0", busy_o); end
   endtask

   task automatic test_zero_rows();
      do_reset();
      pulse_start(0);
      tests++; if ({done_o, busy_o} !== 2'b10) begin fails++; $display("FAIL zero_done: got %b exp 10", {done_o, busy_o}); end
      tick(1);
      tests++; if ({done_o, busy_o} !== 2'b00) begin fails++; $display("FAIL zero_after: got %b exp 00", {done_o, busy_o}); end
   endtask

   task automatic test_start_ignored();
      do_reset();
      pulse_start(2);
      pulse_start(1);
      row_ready_i = 1'b1;
      drive_rows(2, 4, -1, -1, -1);
      tick(3);
      row_ready_i = 1'b0;
      tests++; if (q_tag.size() !== 2) begin fails++; $display("FAIL ign_count: got %0d exp 2", q_tag.size()); end
      for (int i = 0; i < q_last.size(); i++) begin
         tests++; if (q_last[i] !== (i == 1)) begin fails++; $display("FAIL ign_last%0d: got %b exp %b", i, q_last[i], i == 1); end
      end
      tests++; if (done_cnt !== 1) begin fails++; $display("FAIL ign_done: got %0d exp 1", done_cnt); end
   endtask

   task automatic test_stall();
      do_reset();
      drive_rows(7, 0, -1, -1, -1);
      tests++; if (stall_o !== 1'b0) begin fails++; $display("FAIL stall_at7: got %b exp 0", stall_o); end
      drive_rows(1, 7, -1, -1, -1);
      tests++; if (stall_o !== 1'b1) begin fails++; $display("FAIL stall_at8: got %b exp 1", stall_o); end
      drive_rows(1, 8, -1, -1, -1);
      tests++; if (err_o !== 2'b00) begin fails++; $display("FAIL stall_err: got %b exp 00", err_o); end
      row_ready_i = 1'b1;
      tick(12);
      row_ready_i = 1'b0;
      tests++; if (q_tag.size() !== 9) begin fails++; $display("FAIL stall_count: got %0d exp 9", q_tag.size()); end
      for (int i = 0; i < q_tag.size(); i++) begin
         tests++; if (q_data[i] !== exp_row(i)) begin fails++; $display("FAIL stall_row%0d: got %0h exp %0h", i, q_data[i], exp_row(i)); end
      end
      tests++; if (stall_o !== 1'b0) begin fails++; $display("FAIL stall_drained: got %b exp 0", stall_o); end
   endtask

   task automatic test_overflow();
      do_reset();
      drive_rows(17, 0, -1, -1, -1);
      tests++; if (err_o !== 2'b01) begin fails++; $display("FAIL ovf_err: got %b exp 01", err_o); end
      row_ready_i = 1'b1;
      tick(20);
      row_ready_i = 1'b0;
      tests++; if (q_tag.size() !== 16) begin fails++; $display("FAIL ovf_count: got %0d exp 16", q_tag.size()); end
      for (int i = 0; i < q_tag.size(); i++) begin
         tests++; if (q_tag[i] !== i) begin fails++; $display("FAIL ovf_tag%0d: got %0d exp %0d", i, q_tag[i], i); end
      end
   endtask

   task automatic test_skew();
      do_reset();
      row_ready_i = 1'b1;
      drive_rows(1, 5, 3, 5, -1);
      tests++; if (err_o !== 2'b10) begin fails++; $display("FAIL skew_err: got %b exp 10", err_o); end
      tests++; if (q_tag.size() !== 0) begin fails++; $display("FAIL skew_pushed: got %0d exp 0", q_tag.size()); end
      drive_rows(1, 6, -1, -1, -1);
      tick(2);
      row_ready_i = 1'b0;
      tests++; if (q_tag.size() !== 1) begin fails++; $display("FAIL skew_next_count: got %0d exp 1", q_tag.size()); end
      if (q_tag.size() == 1) begin
         tests++; if (q_tag[0] !== 6) begin fails++; $display("FAIL skew_next_tag: got %0d exp 6", q_tag[0]); end
      end
      tests++; if (err_o !== 2'b10) begin fails++; $display("FAIL skew_sticky: got %b exp 10", err_o); end
   endtask

   task automatic test_full_pushpop();
      do_reset();
      drive_rows(16, 0, -1, -1, -1);
      tests++; if ({stall_o, err_o} !== 3'b100) begin fails++; $display("FAIL full_state: got %b exp 100", {stall_o, err_o}); end
      drive_rows(1, 16, -1, -1, COLS - 1);
      tests++; if (err_o !== 2'b00) begin fails++; $display("FAIL full_pp_err: got %b exp 00", err_o); end
      row_ready_i = 1'b1;
      tick(20);
      row_ready_i = 1'b0;
      tests++; if (q_tag.size() !== 17) begin fails++; $display("FAIL full_pp_count: got %0d exp 17", q_tag.size()); end
      for (int i = 0; i < q_tag.size(); i++) begin
         tests++; if (q_tag[i] !== i) begin fails++; $display("FAIL full_pp_tag%0d: got %0d exp %0d", i, q_tag[i], i); end
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      pulse_start(4);
      drive_rows(4, 0, -1, -1, -1);
      row_ready_i = 1'b1;
      tick(2);
      row_ready_i = 1'b0;
      tests++; if (q_tag.size() !== 2) begin fails++; $display("FAIL mid_popped: got %0d exp 2", q_tag.size()); end
      rst = 1'b1;
      #1;
      tests++; if ({row_valid_o, row_last_o, busy_o, done_o, stall_o, err_o} !== 7'b0) begin fails++; $display("FAIL mid_rst_flags: got %b exp 0", {row_valid_o, row_last_o, busy_o, done_o, stall_o, err_o}); end
      tests++; if ({row_cnt_o, row_data_o} !== '0) begin fails++; $display("FAIL mid_rst_row: got %0h exp 0", {row_cnt_o, row_data_o}); end
      tick(1);
      rst = 1'b0;
      tick(2);
      tests++; if (done_cnt !== 0) begin fails++; $display("FAIL mid_no_done: got %0d exp 0", done_cnt); end
      tests++; if (row_valid_o !== 1'b0) begin fails++; $display("FAIL mid_discard: got %b exp 0", row_valid_o); end
      clr_log();
      pulse_start(1);
      row_ready_i = 1'b1;
      drive_rows(1, 9, -1, -1, -1);
      tick(3);
      row_ready_i = 1'b0;
      tests++; if (q_tag.size() !== 1) begin fails++; $display("FAIL mid_new_count: got %0d exp 1", q_tag.size()); end
      if (q_tag.size() == 1) begin
         tests++; if ({q_tag[0], q_last[0]} !== {32'd9, 1'b1}) begin fails++; $display("FAIL mid_new_row: got tag %0d last %b exp tag 9 last 1", q_tag[0], q_last[0]); end
      end
      tests++; if ({done_cnt, busy_o} !== {32'd1, 1'b0}) begin fails++; $display("FAIL mid_new_done: got %0d/%b exp 1/0", done_cnt, busy_o); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_zero_rows();
      test_start_ignored();
      test_stall();
      test_overflow();
      test_skew();
      test_full_pushpop();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
